// File: rtl/lfsr_prng_core.sv
// PRNG core: XNOR Fibonacci data/control LFSRs with a 2:1 bit-pair pick per output bit.
// Free-run tick enables, single-step, hold, seed load with lock-up guard, registered output + valid strobe.
module lfsr_prng_core #(
    parameter int unsigned           OUT_W     = 8,
    parameter logic [2*OUT_W-1:0]    DATA_TAPS = 16'hD008,
    parameter logic [OUT_W-1:0]      CTRL_TAPS = 8'hB8,
    parameter int unsigned           DIV_DATA  = 10_000_000,
    parameter int unsigned           DIV_CTRL  = 8,
    parameter int unsigned           CNT_W     = 24
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 step,
    input  logic                 seed_load,
    input  logic [2*OUT_W-1:0]   seed_data,
    input  logic [OUT_W-1:0]     seed_ctrl,
    output logic [OUT_W-1:0]     rnd_out,
    output logic                 rnd_valid,
    output logic                 seed_err
);

    localparam int unsigned     DATA_W    = 2 * OUT_W;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DIV_DATA - 1);
    localparam logic [CNT_W-1:0] CTRL_LAST = CNT_W'(DIV_CTRL - 1);

    typedef enum logic [1:0] {
        MODE_FREE = 2'b00,
        MODE_STEP = 2'b01,
        MODE_HOLD = 2'b10
    } mode_e;

    logic [DATA_W-1:0] data_q, data_nxt;
    logic [OUT_W-1:0]  ctrl_q, ctrl_nxt;
    logic [CNT_W-1:0]  cnt_d_q, cnt_d_nxt;
    logic [CNT_W-1:0]  cnt_c_q, cnt_c_nxt;
    logic              upd_q, upd_nxt;
    logic [OUT_W-1:0]  rnd_nxt;
    logic              valid_nxt;
    logic              err_nxt;

    logic [DATA_W-1:0] data_adv_c;
    logic [OUT_W-1:0]  ctrl_adv_c;
    logic [OUT_W-1:0]  sel_c;
    logic              data_ones_c;
    logic              ctrl_ones_c;
    mode_e             mode_c;

    assign data_adv_c  = {data_q[DATA_W-2:0], ~^(data_q & DATA_TAPS)};
    assign ctrl_adv_c  = {ctrl_q[OUT_W-2:0],  ~^(ctrl_q & CTRL_TAPS)};
    assign data_ones_c = &seed_data;
    assign ctrl_ones_c = &seed_ctrl;
    assign mode_c      = mode[1] ? MODE_HOLD : mode_e'(mode);

    // Output bit i picks the high or low bit of data pair i under ctrl[i].
    for (genvar i = 0; i < OUT_W; i++) begin : g_sel
        assign sel_c[i] = ctrl_q[i] ? data_q[2*i+1] : data_q[2*i];
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            cnt_d_q   <= '0;
            cnt_c_q   <= '0;
            upd_q     <= 1'b0;
            rnd_out   <= '0;
            rnd_valid <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            data_q    <= data_nxt;
            ctrl_q    <= ctrl_nxt;
            cnt_d_q   <= cnt_d_nxt;
            cnt_c_q   <= cnt_c_nxt;
            upd_q     <= upd_nxt;
            rnd_out   <= rnd_nxt;
            rnd_valid <= valid_nxt;
            seed_err  <= err_nxt;
        end
    end

    // Priority: enable clear, then seed load, then the mode action; upd_q delays the output pick by one edge.
    always_comb begin
        data_nxt  = data_q;
        ctrl_nxt  = ctrl_q;
        cnt_d_nxt = cnt_d_q;
        cnt_c_nxt = cnt_c_q;
        upd_nxt   = 1'b0;
        rnd_nxt   = rnd_out;
        valid_nxt = upd_q;
        err_nxt   = seed_err;

        if (upd_q) begin
            rnd_nxt = sel_c;
        end

        if (!en) begin
            data_nxt  = '0;
            ctrl_nxt  = '0;
            cnt_d_nxt = '0;
            cnt_c_nxt = '0;
            rnd_nxt   = '0;
            valid_nxt = 1'b0;
            err_nxt   = 1'b0;
        end else if (seed_load) begin
            data_nxt  = data_ones_c ? '0 : seed_data;
            ctrl_nxt  = ctrl_ones_c ? '0 : seed_ctrl;
            err_nxt   = data_ones_c | ctrl_ones_c;
            cnt_d_nxt = '0;
            cnt_c_nxt = '0;
            upd_nxt   = 1'b1;
        end else begin
            unique case (mode_c)
                MODE_FREE: begin
                    if (cnt_d_q == DATA_LAST) begin
                        cnt_d_nxt = '0;
                        data_nxt  = data_adv_c;
                        upd_nxt   = 1'b1;
                    end else begin
                        cnt_d_nxt = cnt_d_q + CNT_W'(1);
                    end
                    if (cnt_c_q == CTRL_LAST) begin
                        cnt_c_nxt = '0;
                        ctrl_nxt  = ctrl_adv_c;
                        upd_nxt   = 1'b1;
                    end else begin
                        cnt_c_nxt = cnt_c_q + CNT_W'(1);
                    end
                end
                MODE_STEP: begin
                    cnt_d_nxt = '0;
                    cnt_c_nxt = '0;
                    if (step) begin
                        data_nxt = data_adv_c;
                        ctrl_nxt = ctrl_adv_c;
                        upd_nxt  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
